// File: rtl/mem_line_ctrl_pkg.sv
// Shared types and sizing for the memory-side line controller.
package mem_line_ctrl_pkg;

  localparam int unsigned LINE_BITS       = 128;
  localparam int unsigned BUS_BITS        = 16;
  localparam int unsigned ADDR_BITS       = 14;
  localparam int unsigned LINE_BEATS      = LINE_BITS / BUS_BITS;
  localparam int unsigned BEAT_W          = 3;
  localparam int unsigned MEM_LINES       = 1 << ADDR_BITS;
  localparam int unsigned MEM_LATENCY_DEF = 100;
  localparam int unsigned STAT_W          = 32;

  typedef logic [LINE_BITS-1:0] mem_line_t;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_RECV = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RD_SEND = 3'd3,
    ST_WR_ACK  = 3'd4
  } state_e;

  // Increment that sticks at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Single-port line storage: synchronous read into a holding register, whole-line write.
module mem_line_array
  import mem_line_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  input  mem_line_t            wdata,
  input  logic                 re,
  output mem_line_t            rdata
);

  mem_line_t mem_q [MEM_LINES];
  mem_line_t rdata_q;

  // Storage is never reset; contents survive controller resets.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_line_ctrl.sv
// Memory-side line controller: accepts READ_LINE / WRITE_LINE on bus 2, models a
// fixed access latency and moves lines as eight 16-bit beats, LSB beat first.
// Optional statistics counters are built when MEM_STATS_EN is defined.
module mem_line_ctrl
  import mem_line_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] a2_in,
  input  logic [1:0]           c2_in,
  input  logic [BUS_BITS-1:0]  d2_in,
  output logic [1:0]           c2_out,
  output logic [BUS_BITS-1:0]  d2_out,
  output logic                 busy,
  output logic [STAT_W-1:0]    stat_reads,
  output logic [STAT_W-1:0]    stat_writes,
  output logic [STAT_W-1:0]    stat_drops
);

  localparam int unsigned LAT_W    = $clog2(MEM_LATENCY + 1);
  localparam int unsigned LAT_LOAD = (MEM_LATENCY >= 2) ? MEM_LATENCY - 2 : 0;
  localparam int unsigned WBUF_W   = LINE_BITS - BUS_BITS;

  state_e                state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [WBUF_W-1:0]     wbuf_q, wbuf_d;
  logic [1:0]            c2_out_q, c2_out_d;
  logic                  busy_q, busy_d;

  logic [ADDR_BITS-1:0]  arr_addr;
  logic                  arr_we, arr_re;
  mem_line_t             arr_wdata, arr_rdata;
  c2_cmd_e               cmd;

  assign cmd = c2_cmd_e'(c2_in);

  mem_line_array u_array (
    .clk   (clk),
    .addr  (arr_addr),
    .we    (arr_we & rst_n),
    .wdata (arr_wdata),
    .re    (arr_re & rst_n),
    .rdata (arr_rdata)
  );

  // Next-state, beat capture and storage access control.
  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    c2_out_d  = C2_NOP;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = addr_q;
    arr_wdata = {d2_in, wbuf_q};

    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (cmd == C2_READ_LINE) begin
          addr_d    = a2_in;
          arr_addr  = a2_in;
          arr_re    = 1'b1;
          is_read_d = 1'b1;
          if (MEM_LATENCY == 1) begin
            state_d  = ST_RD_SEND;
            c2_out_d = C2_RESPONSE;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_W'(LAT_LOAD);
          end
        end else if (cmd == C2_WRITE_LINE) begin
          addr_d                = a2_in;
          wbuf_d[BUS_BITS-1:0]  = d2_in;
          beat_d                = BEAT_W'(1);
          is_read_d             = 1'b0;
          state_d               = ST_WR_RECV;
        end
      end

      ST_WR_RECV: begin
        beat_d = beat_q + BEAT_W'(1);
        for (int i = 1; i < int'(LINE_BEATS) - 1; i++) begin
          if (beat_q == BEAT_W'(i)) wbuf_d[i*BUS_BITS +: BUS_BITS] = d2_in;
        end
        // Last beat goes straight into storage with the buffered beats.
        if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
          arr_we = 1'b1;
          if (MEM_LATENCY == 1) begin
            state_d  = ST_WR_ACK;
            c2_out_d = C2_RESPONSE;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_W'(LAT_LOAD);
          end
        end
      end

      ST_WAIT: begin
        if (lat_q == '0) begin
          beat_d   = '0;
          c2_out_d = C2_RESPONSE;
          state_d  = is_read_q ? ST_RD_SEND : ST_WR_ACK;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      ST_RD_SEND: begin
        if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
          beat_d  = '0;
          state_d = ST_IDLE;
        end else begin
          beat_d   = beat_q + BEAT_W'(1);
          c2_out_d = C2_RESPONSE;
        end
      end

      ST_WR_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_read_q <= 1'b0;
      beat_q    <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
      wbuf_q    <= '0;
      c2_out_q  <= C2_NOP;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      c2_out_q  <= c2_out_d;
      busy_q    <= busy_d;
    end
  end

  // Read beat select straight off the array holding register, zero when not sending.
  always_comb begin
    d2_out = '0;
    if (state_q == ST_RD_SEND) begin
      for (int i = 0; i < int'(LINE_BEATS); i++) begin
        if (beat_q == BEAT_W'(i)) d2_out = arr_rdata[i*BUS_BITS +: BUS_BITS];
      end
    end
  end

  assign c2_out = c2_out_q;
  assign busy   = busy_q;

`ifdef MEM_STATS_EN
  logic [STAT_W-1:0] stat_reads_q, stat_reads_d;
  logic [STAT_W-1:0] stat_writes_q, stat_writes_d;
  logic [STAT_W-1:0] stat_drops_q, stat_drops_d;

  // Saturating counts of accepted and dropped commands.
  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    stat_drops_d  = stat_drops_q;
    if (state_q == ST_IDLE) begin
      if (cmd == C2_READ_LINE)  stat_reads_d  = sat_inc(stat_reads_q);
      if (cmd == C2_WRITE_LINE) stat_writes_d = sat_inc(stat_writes_q);
    end else if (busy_q && (state_q != ST_WR_RECV) &&
                 ((cmd == C2_READ_LINE) || (cmd == C2_WRITE_LINE))) begin
      stat_drops_d = sat_inc(stat_drops_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_drops_q  <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_drops_q  <= stat_drops_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_drops  = stat_drops_q;
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl: one instance at latency 4, one at latency 1.
module tb_mem_line_ctrl;
  import mem_line_ctrl_pkg::*;

`ifdef MEM_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [13:0] a2_a, a2_b;
  logic [1:0]  c2_a, c2_b;
  logic [15:0] d2_a, d2_b;
  logic [1:0]  c2o_a, c2o_b;
  logic [15:0] d2o_a, d2o_b;
  logic        busy_a, busy_b;
  logic [31:0] sr_a, sw_a, sd_a, sr_b, sw_b, sd_b;

  mem_line_ctrl #(.MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a2_in(a2_a), .c2_in(c2_a), .d2_in(d2_a),
    .c2_out(c2o_a), .d2_out(d2o_a), .busy(busy_a),
    .stat_reads(sr_a), .stat_writes(sw_a), .stat_drops(sd_a)
  );

  mem_line_ctrl #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a2_in(a2_b), .c2_in(c2_b), .d2_in(d2_b),
    .c2_out(c2o_b), .d2_out(d2o_b), .busy(busy_b),
    .stat_reads(sr_b), .stat_writes(sw_b), .stat_drops(sd_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic [1:0] c2, input logic [13:0] a2,
                       input logic [15:0] d2);
    if (sel) begin c2_b = c2; a2_b = a2; d2_b = d2; end
    else     begin c2_a = c2; a2_a = a2; d2_a = d2; end
  endtask

  function automatic logic [1:0]  obs_c2(input bit sel);   return sel ? c2o_b : c2o_a;   endfunction
  function automatic logic [15:0] obs_d2(input bit sel);   return sel ? d2o_b : d2o_a;   endfunction
  function automatic logic        obs_busy(input bit sel); return sel ? busy_b : busy_a; endfunction

  // Full write: 8 beats, then ack exactly latency cycles after the last beat.
  task automatic wr_line(input bit sel, input logic [13:0] addr, input logic [127:0] line);
    int lat;
    lat = sel ? 1 : 4;
    drive(sel, 2'd3, addr, line[15:0]);
    tick();
    for (int i = 1; i < 8; i++) begin
      check("wr_busy", 32'(obs_busy(sel)), 32'd1);
      drive(sel, 2'd0, addr, line[i*16 +: 16]);
      tick();
    end
    drive(sel, 2'd0, 14'd0, 16'd0);
    for (int k = 1; k < lat; k++) begin
      check("wr_wait_c2", 32'(obs_c2(sel)), 32'd0);
      tick();
    end
    check("wr_ack_c2", 32'(obs_c2(sel)), 32'd1);
    check("wr_ack_d2", 32'(obs_d2(sel)), 32'd0);
    tick();
    check("wr_end_c2", 32'(obs_c2(sel)), 32'd0);
    check("wr_end_busy", 32'(obs_busy(sel)), 32'd0);
  endtask

  // Read: beat 0 exactly latency cycles after the command, 8 beats LSB first.
  task automatic rd_line(input bit sel, input logic [13:0] addr, input logic [127:0] line,
                         input bit drop_last);
    int lat;
    lat = sel ? 1 : 4;
    drive(sel, 2'd2, addr, 16'd0);
    tick();
    drive(sel, 2'd0, 14'd0, 16'd0);
    for (int k = 1; k < lat; k++) begin
      check("rd_wait_c2", 32'(obs_c2(sel)), 32'd0);
      check("rd_wait_d2", 32'(obs_d2(sel)), 32'd0);
      tick();
    end
    for (int b = 0; b < 8; b++) begin
      check("rd_resp_c2", 32'(obs_c2(sel)), 32'd1);
      check("rd_beat_d2", 32'(obs_d2(sel)), 32'(line[b*16 +: 16]));
      if (b == 7 && drop_last) drive(sel, 2'd2, addr, 16'd0);
      tick();
      drive(sel, 2'd0, 14'd0, 16'd0);
    end
    check("rd_end_c2", 32'(obs_c2(sel)), 32'd0);
    check("rd_end_d2", 32'(obs_d2(sel)), 32'd0);
    check("rd_end_busy", 32'(obs_busy(sel)), 32'd0);
  endtask

  logic [127:0] line_inc, line_ones, line_zero, line_aa, line_b;

  initial begin
    line_inc  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    line_ones = {8{16'hFFFF}};
    line_zero = 128'd0;
    line_aa   = {8{16'hAAAA}};
    line_b    = 128'h7777_6666_5555_4444_3333_2222_1111_CAFE;

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 14'd0, 16'd0);
    drive(1'b1, 2'd0, 14'd0, 16'd0);
    tick();
    tick();
    check("rst_c2", 32'(c2o_a), 32'd0);
    check("rst_d2", 32'(d2o_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_stat_reads", sr_a, 32'd0);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_c2", 32'(c2o_a), 32'd0);
      check("idle_d2", 32'(d2o_a), 32'd0);
      check("idle_busy", 32'(busy_a), 32'd0);
    end

    // Write then read back 0x1234
    wr_line(1'b0, 14'h1234, line_inc);
    rd_line(1'b0, 14'h1234, line_inc, 1'b0);

    // Command on the last response cycle is dropped; the next cycle is accepted
    rd_line(1'b0, 14'h1234, line_inc, 1'b1);
    rd_line(1'b0, 14'h1234, line_inc, 1'b0);
    check("stat_drops", sd_a, STATS_ON ? 32'd1 : 32'd0);
    check("stat_reads", sr_a, STATS_ON ? 32'd3 : 32'd0);
    check("stat_writes", sw_a, STATS_ON ? 32'd1 : 32'd0);

    // Address extremes are independent
    wr_line(1'b0, 14'h3FFF, line_ones);
    wr_line(1'b0, 14'h0000, line_zero);
    rd_line(1'b0, 14'h3FFF, line_ones, 1'b0);
    rd_line(1'b0, 14'h0000, line_zero, 1'b0);

    // Reset during a write must not commit partial data
    wr_line(1'b0, 14'h0042, line_aa);
    drive(1'b0, 2'd3, 14'h0042, 16'h5555);
    tick();
    drive(1'b0, 2'd0, 14'h0042, 16'h5555);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_c2", 32'(c2o_a), 32'd0);
    check("midrst_d2", 32'(d2o_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_stat_writes", sw_a, 32'd0);
    check("midrst_stat_drops", sd_a, 32'd0);
    tick();
    check("midrst_hold_c2", 32'(c2o_a), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 14'd0, 16'd0);
    tick();
    check("postrst_busy", 32'(busy_a), 32'd0);
    rd_line(1'b0, 14'h0042, line_aa, 1'b0);

    // Latency 1 instance
    wr_line(1'b1, 14'h0100, line_b);
    rd_line(1'b1, 14'h0100, line_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
